mod_adder_pipe: RTL and testbench

//  Pipelined modular adder for the NTT/poly-arithmetic datapath: result = (in1 + in2) mod q.

---
 rtl/mod_adder_pipe.sv | 129 ++++++++++++
 tb/tb_mod_adder_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_adder_pipe.sv
// Pipelined modular adder: (in1 + in2) mod q in pair mode, or a mod-q sum over a run of
// in1 beats in accumulate mode. Valid/ready on both sides.
module mod_adder_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] modulus_i,
    input  logic                  acc_mode_i,
    input  logic [LEN_WIDTH-1:0]  acc_len_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in1_i,
    input  logic [DATA_WIDTH-1:0] in2_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  acc_last_o,
    output logic                  busy_o
);

    localparam int unsigned SW = DATA_WIDTH + 1;

    logic [SW-1:0]         s1_sum;
    logic                  s1_vld;
    logic                  mode_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] acc_q;

    logic                  adv_c;
    logic                  accept_c;
    logic                  mode_c;
    logic                  pair_beat_c;
    logic                  acc_beat_c;
    logic                  acc_first_c;
    logic                  acc_final_c;
    logic [DATA_WIDTH-1:0] acc_base_c;
    logic [DATA_WIDTH-1:0] acc_red_c;
    logic [DATA_WIDTH-1:0] pair_red_c;

    // Single conditional subtract; valid because both addends are already < q.
    function automatic logic [DATA_WIDTH-1:0] reduce(input logic [SW-1:0] s,
                                                     input logic [DATA_WIDTH-1:0] q);
        return (s >= SW'(q)) ? DATA_WIDTH'(s - SW'(q)) : DATA_WIDTH'(s);
    endfunction

    assign busy_o     = s1_vld | out_valid_o | (cnt_q != '0);
    assign adv_c      = !out_valid_o | out_ready_i;
    assign in_ready_o = adv_c;

    // While idle the live mode input applies, so a beat on the first idle cycle uses it.
    always_comb begin
        accept_c    = in_valid_i & adv_c;
        mode_c      = busy_o ? mode_q : acc_mode_i;
        pair_beat_c = accept_c & !mode_c;
        acc_beat_c  = accept_c & mode_c;
        acc_first_c = (cnt_q == '0);
        acc_final_c = acc_first_c ? (acc_len_i == '0) : (cnt_q == len_q);
        acc_base_c  = acc_first_c ? '0 : acc_q;
        acc_red_c   = reduce(SW'(acc_base_c) + SW'(in1_i), modulus_i);
        pair_red_c  = reduce(s1_sum, modulus_i);
    end

    // Mode latch: frozen while anything is in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= 1'b0;
        end else if (!busy_o) begin
            mode_q <= acc_mode_i;
        end
    end

    // Stage 1: raw (DATA_WIDTH+1)-bit sum of a pair.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_sum <= '0;
            s1_vld <= 1'b0;
        end else if (pair_beat_c) begin
            s1_sum <= SW'(in1_i) + SW'(in2_i);
            s1_vld <= 1'b1;
        end else if (adv_c) begin
            s1_vld <= 1'b0;
        end
    end

    // Accumulator and beat counter for accumulate runs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else if (acc_beat_c) begin
            if (acc_first_c) begin
                len_q <= acc_len_i;
            end
            if (acc_final_c) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_red_c;
                cnt_q <= cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    // Output stage: reduced pair sum or the closing accumulate result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            result_o    <= '0;
            acc_last_o  <= 1'b0;
        end else if (adv_c) begin
            if (acc_beat_c && acc_final_c) begin
                out_valid_o <= 1'b1;
                result_o    <= acc_red_c;
                acc_last_o  <= 1'b1;
            end else begin
                out_valid_o <= s1_vld;
                acc_last_o  <= 1'b0;
                if (s1_vld) begin
                    result_o <= pair_red_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_adder_pipe.sv
// Randomised bench for mod_adder_pipe: a queue-based mod-q model predicts every result,
// with literal values pinning the directed cases.
module tb_mod_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] modulus = 16'd3329;
    logic        acc_mode = 1'b0;
    logic [8:0]  acc_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        acc_last;
    logic        busy;

    mod_adder_pipe #(.DATA_WIDTH(16), .LEN_WIDTH(9)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .modulus_i  (modulus),
        .acc_mode_i (acc_mode),
        .acc_len_i  (acc_len),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in1_i      (in1),
        .in2_i      (in2),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .acc_last_o (acc_last),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        bit last;
        bit pair;
        int acyc;
        int astall;
        bit has_lit;
        int lit;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   stalls = 0;
    int   m_sum = 0;
    int   m_cnt = 0;
    int   m_len = 0;
    bit   prev_stall = 0;
    int   prev_res = 0;
    bit   prev_last = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit   lit_en = 0;
    int   lit_val = 0;
    bit   gaps = 0;

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(3, 0) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor and model: everything sampled at the falling edge, handshakes complete at the next rise.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            m_sum = 0;
            m_cnt = 0;
            prev_stall = 0;
        end else begin
            check_eq("in_ready", in_ready, (!out_valid || out_ready));
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_result", result, prev_res);
                check_eq("hold_last", acc_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_output", result, -1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("result", result, e.res);
                    check_eq("acc_last", acc_last, e.last);
                    if (e.has_lit) check_eq("literal", result, e.lit);
                    if (e.astall == stalls)
                        check_eq("latency", cyc - e.acyc, e.pair ? 2 : 1);
                end
            end
            if (out_valid && !out_ready) stalls++;
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            prev_last  = acc_last;
            if (in_valid && in_ready) begin
                if (!acc_mode) begin
                    e = '{res: (int'(in1) + int'(in2)) % int'(modulus), last: 0, pair: 1,
                          acyc: cyc, astall: stalls, has_lit: lit_en, lit: lit_val};
                    exp_q.push_back(e);
                end else begin
                    if (m_cnt == 0) begin
                        m_len = int'(acc_len);
                        m_sum = 0;
                    end
                    m_sum = (m_sum + int'(in1)) % int'(modulus);
                    if (m_cnt == m_len) begin
                        e = '{res: m_sum, last: 1, pair: 0, acyc: cyc, astall: stalls,
                              has_lit: lit_en, lit: lit_val};
                        exp_q.push_back(e);
                        m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    end

    task automatic beat(input int a, input int b, input bit le, input int lv);
        bit got;
        if (gaps) repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        in1 = 16'(a);
        in2 = 16'(b);
        lit_en = le;
        lit_val = lv;
        in_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        if (!got) check_eq("accept_timeout", 0, 1);
        in_valid = 1'b0;
        lit_en = 0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            idle = !busy && (exp_q.size() == 0);
        end
        if (!idle) check_eq("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_result"}, result, 0);
        check_eq({tag, "_acc_last"}, acc_last, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int q;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pair mode, small modulus
        modulus = 16'd3329;
        acc_mode = 1'b0;
        beat(3000, 500, 1, 171);
        beat(0, 0, 1, 0);
        beat(3328, 3328, 1, 3327);
        wait_idle();

        // Largest modulus exercises the carry bit
        modulus = 16'd65535;
        beat(65534, 65534, 1, 65533);
        beat(1, 65533, 1, 65534);
        wait_idle();

        // Eight back-to-back pairs, no back-pressure
        modulus = 16'd3329;
        for (int i = 0; i < 8; i++) beat($urandom_range(3328, 0), $urandom_range(3328, 0), 0, 0);
        wait_idle();

        // Output held off for five cycles mid-stream
        fork
            for (int i = 0; i < 8; i++) beat($urandom_range(3328, 0), $urandom_range(3328, 0), 0, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                rdy_mode = 2;
                repeat (5) @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        wait_idle();

        // Accumulate runs
        acc_mode = 1'b1;
        acc_len = 9'd3;
        for (int i = 0; i < 4; i++) beat(3000, 7, (i == 3), 2013);
        wait_idle();
        acc_len = 9'd0;
        beat(5, 0, 1, 5);
        wait_idle();

        // Reset in the middle of a run, then a fresh run
        acc_len = 9'd3;
        beat(3000, 0, 0, 0);
        beat(3000, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) beat(3000, 0, (i == 3), 2013);
        wait_idle();

        // Random rounds: random modulus, mode, gaps and back-pressure
        gaps = 1;
        for (int r = 0; r < 12; r++) begin
            wait_idle();
            q = (r % 3 == 0) ? 65535 : int'($urandom_range(65535, 2));
            modulus = 16'(q);
            acc_mode = r[0];
            rdy_mode = 1;
            if (!acc_mode) begin
                for (int i = 0; i < 40; i++)
                    beat($urandom_range(q - 1, 0), $urandom_range(q - 1, 0), 0, 0);
            end else begin
                for (int k = 0; k < 5; k++) begin
                    acc_len = 9'($urandom_range(9, 0));
                    for (int i = 0; i <= int'(acc_len); i++)
                        beat($urandom_range(q - 1, 0), $urandom, 0, 0);
                end
            end
            rdy_mode = 0;
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
